// File: rtl/mmcm_ps_pkg.sv
// Types and default constants shared by the phase-shift responder and the
// fine-delay controller, so both ends use the same step arithmetic.
package mmcm_ps_pkg;

    typedef enum logic [1:0] {
        LOCKING = 2'd0,
        IDLE    = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } ps_resp_state_t;

    localparam int PS_LATENCY_DEF       = 12;
    localparam int STEPS_PER_PERIOD_DEF = 497;
    localparam int STEP_PS_X100_DEF     = 2012;
    localparam int STEP_W_DEF           = 9;
    localparam int LOCK_DELAY_DEF       = 64;

    // One phase step in either direction, wrapping modulo the clock period.
    function automatic int wrap_step(input int cur, input logic inc, input int period);
        if (inc) begin
            return (cur == period - 1) ? 0 : cur + 1;
        end
        return (cur == 0) ? period - 1 : cur - 1;
    endfunction

endpackage

// File: rtl/mmcm_ps_responder_if.sv
// Dynamic phase-shift handshake between an initiator (master) and the
// responder (slave).
interface mmcm_ps_responder_if;
    logic psen;
    logic psincdec;
    logic ps_done;
    logic busy;
    logic locked;

    modport master (
        output psen,
        output psincdec,
        input  ps_done,
        input  busy,
        input  locked
    );

    modport slave (
        input  psen,
        input  psincdec,
        output ps_done,
        output busy,
        output locked
    );
endinterface

// File: rtl/ps_step_to_ps.sv
// Registered conversion of a phase-step count to picoseconds (truncated).
module ps_step_to_ps
    import mmcm_ps_pkg::*;
#(
    parameter int STEP_W       = STEP_W_DEF,
    parameter int STEP_PS_X100 = STEP_PS_X100_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STEP_W-1:0] steps,
    output logic [15:0]       phase_ps
);

    logic [23:0] product_next;

    assign product_next = 24'(steps) * 24'(STEP_PS_X100);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_ps <= 16'd0;
        end else begin
            phase_ps <= 16'(product_next / 24'd100);
        end
    end

endmodule

// File: rtl/mmcm_ps_responder.sv
// Behavioural stand-in for the MMCM fine phase-shift port: fixed-latency
// PSDONE, modulo-period phase tracking and sticky protocol-violation flag.
module mmcm_ps_responder
    import mmcm_ps_pkg::*;
#(
    parameter int PS_LATENCY       = PS_LATENCY_DEF,
    parameter int STEPS_PER_PERIOD = STEPS_PER_PERIOD_DEF,
    parameter int STEP_W           = STEP_W_DEF,
    parameter int STEP_PS_X100     = STEP_PS_X100_DEF,
    parameter int LOCK_DELAY       = LOCK_DELAY_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mmcm_ps_responder_if.slave   ps,
    input  logic                 err_clr,
    output logic [STEP_W-1:0]    phase_steps,
    output logic [15:0]          phase_ps,
    output logic                 protocol_err
);

    localparam int LOCK_W = $clog2(LOCK_DELAY + 1);

    ps_resp_state_t    state_reg;
    logic [LOCK_W-1:0] lock_cnt_reg;
    logic [7:0]        lat_cnt_reg;
    logic              dir_reg;
    logic              psen_prev_reg;
    logic [STEP_W-1:0] phase_reg;
    logic              done_reg;
    logic              busy_reg;
    logic              locked_reg;
    logic              err_reg;

    logic              accept_next;
    logic              violation_next;
    logic [STEP_W-1:0] phase_next;

    // A request is only honoured in IDLE and only on the rising cycle of psen;
    // anything else is ignored apart from raising the error flag.
    assign accept_next    = ps.psen && (state_reg == IDLE) && !psen_prev_reg;
    assign violation_next = ps.psen && !accept_next;
    assign phase_next     = STEP_W'(wrap_step(int'(phase_reg), dir_reg, STEPS_PER_PERIOD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= LOCKING;
            lock_cnt_reg  <= '0;
            lat_cnt_reg   <= '0;
            dir_reg       <= 1'b0;
            psen_prev_reg <= 1'b0;
            phase_reg     <= '0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            psen_prev_reg <= ps.psen;
            done_reg      <= 1'b0;

            // A violation coincident with err_clr keeps the flag set.
            if (violation_next) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end

            case (state_reg)
                LOCKING: begin
                    if (lock_cnt_reg == LOCK_W'(LOCK_DELAY - 1)) begin
                        state_reg  <= IDLE;
                        locked_reg <= 1'b1;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept_next) begin
                        dir_reg     <= ps.psincdec;
                        lat_cnt_reg <= 8'(PS_LATENCY - 2);
                        busy_reg    <= 1'b1;
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    if (lat_cnt_reg == 8'd0) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    phase_reg <= phase_next;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= LOCKING;
                end
            endcase
        end
    end

    assign ps.ps_done   = done_reg;
    assign ps.busy      = busy_reg;
    assign ps.locked    = locked_reg;
    assign phase_steps  = phase_reg;
    assign protocol_err = err_reg;

    ps_step_to_ps #(
        .STEP_W       (STEP_W),
        .STEP_PS_X100 (STEP_PS_X100)
    ) u_step_to_ps (
        .clk      (clk),
        .rst_n    (rst_n),
        .steps    (phase_reg),
        .phase_ps (phase_ps)
    );

endmodule

// File: tb/tb_mmcm_ps_responder.sv
// Self-checking bench for mmcm_ps_responder: vector table, protocol corner
// sequences and randomized shifts against an arithmetic phase model.
module tb_mmcm_ps_responder;

    localparam int SPP      = 497;
    localparam int STEP_X   = 2012;
    localparam int LAT      = 12;
    localparam int LOCK_DLY = 64;

    logic       clk;
    logic       rst_n;
    logic       err_clr;
    logic [8:0] phase_steps;
    logic [15:0] phase_ps;
    logic       protocol_err;

    mmcm_ps_responder_if ps_if ();

    mmcm_ps_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps           (ps_if.slave),
        .err_clr      (err_clr),
        .phase_steps  (phase_steps),
        .phase_ps     (phase_ps),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int model = 0;

    // Counts completion pulses seen at each active edge.
    always @(posedge clk) begin
        if (ps_if.ps_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        bit inc;
        int exp_steps;
        int exp_ps;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_next(input int cur, input bit inc);
        return inc ? (cur + 1) % SPP : (cur + SPP - 1) % SPP;
    endfunction

    function automatic int model_ps(input int s);
        return (s * STEP_X) / 100;
    endfunction

    // Issue one request and return how many cycles until ps_done (-1 on timeout).
    task automatic shift(input bit inc, output int lat);
        @(negedge clk);
        ps_if.psen     = 1'b1;
        ps_if.psincdec = inc;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) ps_if.psen = 1'b0;
            if (ps_if.ps_done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic relock_check(input string tag);
        for (int j = 1; j <= LOCK_DLY; j++) begin
            @(negedge clk);
            if (j == LOCK_DLY - 1) check({tag, "_locked_early"}, int'(ps_if.locked), 0);
            if (j == LOCK_DLY)     check({tag, "_locked"}, int'(ps_if.locked), 1);
        end
    endtask

    initial begin
        int lat;
        int d0;
        int first_done;

        vecs[0] = '{1'b1,   1,   20};
        vecs[1] = '{1'b0,   0,    0};
        vecs[2] = '{1'b0, 496, 9979};
        vecs[3] = '{1'b1,   0,    0};
        vecs[4] = '{1'b0, 496, 9979};
        vecs[5] = '{1'b0, 495, 9959};
        vecs[6] = '{1'b1, 496, 9979};
        vecs[7] = '{1'b1,   0,    0};

        rst_n = 1'b0;
        err_clr = 1'b0;
        ps_if.psen = 1'b0;
        ps_if.psincdec = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ps_done", int'(ps_if.ps_done), 0);
        check("rst_busy", int'(ps_if.busy), 0);
        check("rst_locked", int'(ps_if.locked), 0);
        check("rst_phase_steps", int'(phase_steps), 0);
        check("rst_phase_ps", int'(phase_ps), 0);
        check("rst_protocol_err", int'(protocol_err), 0);

        // Lock sequence with an illegal request while still locking.
        d0 = done_cnt;
        rst_n = 1'b1;
        for (int k = 1; k <= LOCK_DLY; k++) begin
            @(negedge clk);
            if (k == LOCK_DLY - 1) check("lock_early", int'(ps_if.locked), 0);
            if (k == LOCK_DLY)     check("lock_rise", int'(ps_if.locked), 1);
            if (k == 10) ps_if.psen = 1'b1;
            if (k == 11) ps_if.psen = 1'b0;
        end
        check("locking_psen_err", int'(protocol_err), 1);
        check("locking_psen_steps", int'(phase_steps), 0);
        check("locking_psen_done", done_cnt - d0, 0);

        pulse_err_clr();
        check("err_clr", int'(protocol_err), 0);

        // Vector table: each shift checked for latency and both phase outputs.
        for (int v = 0; v < 8; v++) begin
            shift(vecs[v].inc, lat);
            model = model_next(model, vecs[v].inc);
            check($sformatf("vec%0d_latency", v), lat, LAT);
            @(negedge clk);
            check($sformatf("vec%0d_steps", v), int'(phase_steps), vecs[v].exp_steps);
            check($sformatf("vec%0d_model", v), int'(phase_steps), model);
            @(negedge clk);
            check($sformatf("vec%0d_ps", v), int'(phase_ps), vecs[v].exp_ps);
        end

        // A full period of back-to-back increments returns to the start.
        for (int i = 0; i < SPP; i++) begin
            shift(1'b1, lat);
            model = model_next(model, 1'b1);
            check($sformatf("b2b%0d_latency", i), lat, LAT);
        end
        @(negedge clk);
        check("b2b_steps", int'(phase_steps), model);
        check("b2b_steps_zero", int'(phase_steps), 0);
        @(negedge clk);
        check("b2b_ps", int'(phase_ps), 0);

        shift(1'b0, lat);
        model = model_next(model, 1'b0);
        check("wrap_dec_latency", lat, LAT);
        @(negedge clk);
        check("wrap_dec_steps", int'(phase_steps), 496);
        @(negedge clk);
        check("wrap_dec_ps", int'(phase_ps), 9979);

        // Requests while busy and coincident with ps_done are ignored.
        d0 = done_cnt;
        first_done = -1;
        @(negedge clk);
        ps_if.psen = 1'b1;
        ps_if.psincdec = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ps_if.ps_done === 1'b1 && first_done < 0) first_done = k;
            if (k == 1)  ps_if.psen = 1'b0;
            if (k == 5)  begin ps_if.psen = 1'b1; ps_if.psincdec = 1'b0; end
            if (k == 6)  ps_if.psen = 1'b0;
            if (k == 12) begin ps_if.psen = 1'b1; ps_if.psincdec = 1'b0; end
            if (k == 13) ps_if.psen = 1'b0;
        end
        model = model_next(model, 1'b1);
        check("busy_viol_latency", first_done, LAT);
        check("busy_viol_done_count", done_cnt - d0, 1);
        check("busy_viol_err", int'(protocol_err), 1);
        check("busy_viol_steps", int'(phase_steps), model);
        pulse_err_clr();
        check("busy_viol_err_clr", int'(protocol_err), 0);

        // Violation in the same cycle as err_clr keeps the flag set.
        @(negedge clk);
        ps_if.psen = 1'b1;
        ps_if.psincdec = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) ps_if.psen = 1'b0;
            if (k == 3) begin ps_if.psen = 1'b1; ps_if.psincdec = 1'b0; err_clr = 1'b1; end
            if (k == 4) begin ps_if.psen = 1'b0; err_clr = 1'b0; end
            if (k == 5) check("clr_vs_viol_err", int'(protocol_err), 1);
        end
        model = model_next(model, 1'b1);
        check("clr_vs_viol_steps", int'(phase_steps), model);
        pulse_err_clr();

        // psen held for two cycles in IDLE: only the first is taken.
        d0 = done_cnt;
        first_done = -1;
        @(negedge clk);
        ps_if.psen = 1'b1;
        ps_if.psincdec = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ps_if.ps_done === 1'b1 && first_done < 0) first_done = k;
            if (k == 2) ps_if.psen = 1'b0;
        end
        model = model_next(model, 1'b0);
        check("double_psen_latency", first_done, LAT);
        check("double_psen_done_count", done_cnt - d0, 1);
        check("double_psen_err", int'(protocol_err), 1);
        check("double_psen_steps", int'(phase_steps), model);
        pulse_err_clr();

        // Reset in the middle of a shift abandons it.
        d0 = done_cnt;
        @(negedge clk);
        ps_if.psen = 1'b1;
        ps_if.psincdec = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) ps_if.psen = 1'b0;
            if (k == 6) rst_n = 1'b0;
        end
        check("midrst_locked", int'(ps_if.locked), 0);
        check("midrst_busy", int'(ps_if.busy), 0);
        check("midrst_steps", int'(phase_steps), 0);
        rst_n = 1'b1;
        model = 0;
        relock_check("midrst_relock");
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_ps", int'(phase_ps), 0);

        // Randomized shifts against the phase model.
        for (int r = 0; r < 40; r++) begin
            bit inc;
            int gap;
            gap = $urandom_range(0, 3);
            inc = 1'($urandom_range(0, 1));
            repeat (gap) @(negedge clk);
            shift(inc, lat);
            model = model_next(model, inc);
            check($sformatf("rnd%0d_latency", r), lat, LAT);
            @(negedge clk);
            check($sformatf("rnd%0d_steps", r), int'(phase_steps), model);
            @(negedge clk);
            check($sformatf("rnd%0d_ps", r), int'(phase_ps), model_ps(model));
        end
        check("rnd_no_err", int'(protocol_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
